vector_fp_merge_unit: RTL and testbench
=======================================

// Module: vector_fp_merge_unit
//
// PURPOSE
// - Executes RVV vfmerge.vfm in the vector FP execution lane:
//   vd[i] = v0.mask[i] ? f[rs1] : vs2[i].
// - Purely bitwise select: no arithmetic, no rounding, no fflags, NaNs passed unchanged.
// - Single registered stage between the vector issue stage and the vector register
//   file write-back.
//
// PARAMETERS
// - VLEN  64  vector register width in bits; multiple of 64.
// - VLMAX_W  $clog2(VLEN/16)+1  width of vl; derived, not overridden.
//
// PORTS
// - clock       in   1        single clock; all state updates on rising edge.
// - reset       in   1        synchronous, active-high.
// - valid_in    in   1        issue strobe; inputs sampled when high.
// - merge_en    in   1        1 = vfmerge.vfm decoded; 0 = not this unit's op.
// - vsew        in   2        00=SEW8 (illegal for FP), 01=SEW16, 10=SEW32, 11=SEW64.
// - vl          in   VLMAX_W  active element count.
// - vs2         in   VLEN     vector operand selected where mask=0.
// - vs1         in   VLEN     scalar carrier; fs1 = vs1[SEW-1:0].
// - v0          in   VLEN     mask register; bit i masks element i.
// - vd_old      in   VLEN     current destination contents; used for tail elements.
// - vd          out  VLEN     result.
// - vd_valid    out  1        result strobe.
// - illegal     out  1        illegal-SEW flag, qualified by vd_valid.
//
// BEHAVIOUR
// - Reset: vd=0, vd_valid=0, illegal=0 on the first rising edge with reset=1.
//   - Reset overrides any in-flight op; no result is produced for it.
// - Latency: exactly 1 cycle.
//   - Sampling edge: valid_in & merge_en sampled high.
//   - Next cycle: vd/vd_valid present for that op.
//   - Throughput: 1 op/cycle; no stall or backpressure.
// - Idle: valid_in=0 or merge_en=0 gives vd_valid=0 and illegal=0 next cycle; vd holds its last value.
// - Elements: N = VLEN/SEW, numbered i = 0..N-1, element i = bits [i*SEW +: SEW].
// - vl handling:
//   - vl_eff = min(vl, N).
//   - Active element (i < vl_eff): v0[i] ? fs1 : vs2 element i.
//   - Tail element (i >= vl_eff): vd_old element i (tail-undisturbed).
//   - vl=0: vd = vd_old.
// - Mask indexing: only v0[N-1:0] is used; higher v0 bits are ignored.
// - fs1 width: low SEW bits of vs1, replicated to every selected slot.
//   - No NaN-box check; vs1 upper bits are ignored.
// - Illegal SEW (vsew=00) with a valid merge op:
//   - vd = vd_old, vd_valid=1, illegal=1.
// - Legal SEW: illegal=0.
// - Implementation shape: compute all three SEW results in parallel, then a final mux on vsew.
//
// TESTING (VLEN=64)
// - SEW64, vl=1, v0[0]=1, vs1=0x3FF0000000000000, vs2=0x4000000000000000
//   -> next cycle vd=0x3FF0000000000000, vd_valid=1, illegal=0.
// - SEW32, vl=2, v0=0b10, vs1[31:0]=0x3F800000, vs2=0x40000000_40400000
//   -> vd=0x3F800000_40400000.
// - SEW32, vl=1, v0=0b11, vs1[31:0]=0x3F800000, vd_old=0xAAAAAAAA_BBBBBBBB
//   -> vd=0xAAAAAAAA_3F800000 (element 1 is tail).
// - SEW16, vl=7 (clamped to 4), v0=0b0101, vs1[15:0]=0x3C00, vs2=0x1111_2222_3333_4444
//   -> vd=0x1111_3C00_3333_3C00.
// - vsew=00, valid merge op, vd_old=0x0123456789ABCDEF
//   -> vd=0x0123456789ABCDEF, vd_valid=1, illegal=1.
// - Reset asserted the cycle after a valid op
//   -> following edge: vd=0, vd_valid=0, illegal=0.
// - Back-to-back ops on consecutive cycles -> one result per cycle, in order.

Source files
------------

// File: rtl/vector_fp_merge_unit.sv
// Single-stage vfmerge.vfm datapath: per-element select between the fs1 scalar and vs2,
// with tail-undisturbed fill from vd_old, registered once ahead of write-back.
module vector_fp_merge_unit #(
    parameter  int VLEN    = 64,
    localparam int VLMAX_W = $clog2(VLEN / 16) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               merge_en,
    input  logic [1:0]         vsew,
    input  logic [VLMAX_W-1:0] vl,
    input  logic [VLEN-1:0]    vs2,
    input  logic [VLEN-1:0]    vs1,
    input  logic [VLEN-1:0]    v0,
    input  logic [VLEN-1:0]    vd_old,
    output logic [VLEN-1:0]    vd,
    output logic               vd_valid,
    output logic               illegal
);

    logic [VLEN-1:0] res16, res32, res64;
    logic [VLEN-1:0] vd_d, vd_q;
    logic            vd_valid_q, illegal_q;
    logic            fire;
    logic            unused_bits;

    assign fire = valid_in & merge_en;

    // Only the low mask bits and low scalar bits matter; fold the rest into a sink.
    assign unused_bits = ^{v0, vs1};

    // Element indices never exceed N-1, so comparing against raw vl already clamps to N.
    always_comb begin
        res16 = vd_old;
        res32 = vd_old;
        res64 = vd_old;
        for (int i = 0; i < VLEN / 16; i++) begin
            if (VLMAX_W'(i) < vl) begin
                res16[i*16 +: 16] = v0[i] ? vs1[15:0] : vs2[i*16 +: 16];
            end
        end
        for (int i = 0; i < VLEN / 32; i++) begin
            if (VLMAX_W'(i) < vl) begin
                res32[i*32 +: 32] = v0[i] ? vs1[31:0] : vs2[i*32 +: 32];
            end
        end
        for (int i = 0; i < VLEN / 64; i++) begin
            if (VLMAX_W'(i) < vl) begin
                res64[i*64 +: 64] = v0[i] ? vs1[63:0] : vs2[i*64 +: 64];
            end
        end
    end

    always_comb begin
        vd_d = vd_old;
        case (vsew)
            2'b01:   vd_d = res16;
            2'b10:   vd_d = res32;
            2'b11:   vd_d = res64;
            default: vd_d = vd_old;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vd_q       <= '0;
            vd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            vd_valid_q <= fire;
            illegal_q  <= fire && (vsew == 2'b00);
            if (fire) begin
                vd_q <= vd_d;
            end
        end
    end

    assign vd       = vd_q;
    assign vd_valid = vd_valid_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_vector_fp_merge_unit.sv
// Bench for vector_fp_merge_unit (VLEN=64): directed literal cases plus random traffic
// compared every cycle against an element-level reference model.
module tb_vector_fp_merge_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in, merge_en;
    logic [1:0]  vsew;
    logic [2:0]  vl;
    logic [63:0] vs2, vs1, v0, vd_old;
    logic [63:0] vd;
    logic        vd_valid, illegal;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_vd;
    logic        exp_valid, exp_ill;
    bit          model_ok = 1'b0;

    vector_fp_merge_unit #(.VLEN(64)) dut (
        .clock    (clock),
        .reset    (reset),
        .valid_in (valid_in),
        .merge_en (merge_en),
        .vsew     (vsew),
        .vl       (vl),
        .vs2      (vs2),
        .vs1      (vs1),
        .v0       (v0),
        .vd_old   (vd_old),
        .vd       (vd),
        .vd_valid (vd_valid),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [1:0] s, input logic [2:0] l,
                                          input logic [63:0] a2, input logic [63:0] a1,
                                          input logic [63:0] mk, input logic [63:0] old);
        int          sew, n, vle;
        logic [63:0] mask, r, el;
        if (s == 2'b00) return old;
        sew  = 8 << s;
        n    = 64 / sew;
        vle  = (int'(l) < n) ? int'(l) : n;
        mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
        r    = old;
        for (int i = 0; i < vle; i++) begin
            el = mk[i] ? (a1 & mask) : ((a2 >> (i * sew)) & mask);
            r  = (r & ~(mask << (i * sew))) | (el << (i * sew));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic [1:0] s, input logic [2:0] l,
                         input logic [63:0] a2, input logic [63:0] a1,
                         input logic [63:0] mk, input logic [63:0] old);
        valid_in = v;
        merge_en = m;
        vsew     = s;
        vl       = l;
        vs2      = a2;
        vs1      = a1;
        v0       = mk;
        vd_old   = old;
    endtask

    task automatic directed(input string nm, input logic [1:0] s, input logic [2:0] l,
                            input logic [63:0] a2, input logic [63:0] a1,
                            input logic [63:0] mk, input logic [63:0] old,
                            input logic [63:0] exp_v, input logic exp_i);
        chk({nm, "_model"}, model(s, l, a2, a1, mk, old), exp_v);
        drive(1'b1, 1'b1, s, l, a2, a1, mk, old);
        @(negedge clock);
        chk({nm, "_vd"}, vd, exp_v);
        chk({nm, "_valid"}, {63'd0, vd_valid}, 64'd1);
        chk({nm, "_illegal"}, {63'd0, illegal}, {63'd0, exp_i});
    endtask

    // Reference state: what the outputs must show after each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            exp_vd    <= 64'd0;
            exp_valid <= 1'b0;
            exp_ill   <= 1'b0;
            model_ok  <= 1'b1;
        end else if (valid_in && merge_en) begin
            exp_vd    <= model(vsew, vl, vs2, vs1, v0, vd_old);
            exp_valid <= 1'b1;
            exp_ill   <= (vsew == 2'b00);
        end else begin
            exp_valid <= 1'b0;
            exp_ill   <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("cyc_vd", vd, exp_vd);
            chk("cyc_valid", {63'd0, vd_valid}, {63'd0, exp_valid});
            chk("cyc_illegal", {63'd0, illegal}, {63'd0, exp_ill});
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        directed("sew64", 2'b11, 3'd1, 64'h4000000000000000, 64'h3FF0000000000000,
                 64'h1, 64'h0, 64'h3FF0000000000000, 1'b0);
        directed("sew32", 2'b10, 3'd2, 64'h40000000_40400000, 64'hDEADBEEF_3F800000,
                 64'h2, 64'h5555_5555_5555_5555, 64'h3F800000_40400000, 1'b0);
        directed("sew32_tail", 2'b10, 3'd1, 64'h12345678_9ABCDEF0, 64'h3F800000,
                 64'h3, 64'hAAAAAAAA_BBBBBBBB, 64'hAAAAAAAA_3F800000, 1'b0);
        directed("sew16_clamp", 2'b01, 3'd7, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_3C00,
                 64'hFFFF_FFFF_FFFF_FFF5, 64'h0, 64'h1111_3C00_3333_3C00, 1'b0);
        directed("sew16_vl0", 2'b01, 3'd0, 64'h1111_2222_3333_4444, 64'h3C00,
                 64'hF, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 1'b0);
        directed("sew8_illegal", 2'b00, 3'd4, 64'hFFFF_0000_FFFF_0000, 64'h77,
                 64'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b1);

        // Idle cycles: valid low, then valid high without merge_en; vd must hold.
        drive(1'b0, 1'b1, 2'b11, 3'd1, 64'h1, 64'h2, 64'h1, 64'h3);
        @(negedge clock);
        drive(1'b1, 1'b0, 2'b11, 3'd1, 64'h1, 64'h2, 64'h1, 64'h3);
        @(negedge clock);
        chk("idle_hold_vd", vd, 64'h0123456789ABCDEF);
        chk("idle_valid", {63'd0, vd_valid}, 64'd0);

        // Reset the cycle after a valid op, with another op presented during reset.
        drive(1'b1, 1'b1, 2'b11, 3'd1, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 64'h1, 64'h0);
        @(negedge clock);
        chk("pre_reset_vd", vd, 64'h5A5A_5A5A_5A5A_5A5A);
        reset = 1'b1;
        drive(1'b1, 1'b0 | 1'b1, 2'b00, 3'd1, 64'h0, 64'h1, 64'h1, 64'hFFFF);
        @(negedge clock);
        chk("reset_vd", vd, 64'd0);
        chk("reset_valid", {63'd0, vd_valid}, 64'd0);
        chk("reset_illegal", {63'd0, illegal}, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clock);
        end

        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
